// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register plus EX-side operand selection.
//
// Latches the decoded instruction, resolves RAW hazards by forwarding from
// EX/MEM and MEM/WB, and drives the ALU A/B/ALUOp inputs. It detects load-use
// hazards (stall decode, insert a bubble) and kills the entering instruction
// on a branch/jump flush. A downstream stall freezes the whole stage.
//
// Build option: define EX_FORWARD_EN to enable the forwarding muxes. Without
// it the operands come straight from the latched register data, and the
// hazard rule widens so that decode stalls on any read of a register still
// being produced in EX or EX/MEM.

module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [3:0]        id_alu_op_i,
    input  logic [1:0]        id_asel_i,
    input  logic              id_bsel_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic              flush_i,
    input  logic              mem_stall_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_reg_write_i,
    input  logic [XLEN-1:0]   exmem_result_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_reg_write_i,
    input  logic [XLEN-1:0]   memwb_result_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   alu_a_o,
    output logic [XLEN-1:0]   alu_b_o,
    output logic [3:0]        alu_op_o,
    output logic [XLEN-1:0]   ex_store_data_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic [XLEN-1:0]   ex_pc_o
);

    // ID/EX register fields
    logic              ex_valid_r;
    logic [XLEN-1:0]   ex_pc_r;
    logic [REG_AW-1:0] ex_rs1_r;
    logic [REG_AW-1:0] ex_rs2_r;
    logic [REG_AW-1:0] ex_rd_r;
    logic [XLEN-1:0]   ex_rs1_data_r;
    logic [XLEN-1:0]   ex_rs2_data_r;
    logic [XLEN-1:0]   ex_imm_r;
    logic [3:0]        ex_alu_op_r;
    logic [1:0]        ex_asel_r;
    logic              ex_bsel_r;
    logic              ex_reg_write_r;
    logic              ex_mem_read_r;
    logic              ex_mem_write_r;

    logic              hazard_s;
    logic              bubble_s;
    logic [XLEN-1:0]   fwd_rs1_s;
    logic [XLEN-1:0]   fwd_rs2_s;

    // Hazard detection between the decode instruction and older producers
    always_comb begin
        hazard_s = 1'b0;
`ifdef EX_FORWARD_EN
        // Only a load in EX cannot be forwarded in time.
        if (ex_valid_r && ex_mem_read_r && (ex_rd_r != {REG_AW{1'b0}}) && id_valid_i &&
            ((id_uses_rs1_i && (id_rs1_i == ex_rd_r)) ||
             (id_uses_rs2_i && (id_rs2_i == ex_rd_r)))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
`else
        // No bypass: any producer still in EX or EX/MEM blocks the reader.
        // MEM/WB is covered by the write-before-read register file.
        if (id_valid_i &&
            ((ex_valid_r && ex_reg_write_r && (ex_rd_r != {REG_AW{1'b0}}) &&
              ((id_uses_rs1_i && (id_rs1_i == ex_rd_r)) ||
               (id_uses_rs2_i && (id_rs2_i == ex_rd_r)))) ||
             (exmem_reg_write_i && (exmem_rd_i != {REG_AW{1'b0}}) &&
              ((id_uses_rs1_i && (id_rs1_i == exmem_rd_i)) ||
               (id_uses_rs2_i && (id_rs2_i == exmem_rd_i)))))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
`endif
    end

    // A flush or a load-use hazard turns the next load into a bubble
    always_comb begin
        if (flush_i || hazard_s) begin
            bubble_s = 1'b1;
        end else begin
            bubble_s = 1'b0;
        end
    end

    // Decode must hold while the stage is frozen or a hazard bubble goes in;
    // a flushed decode slot is being discarded anyway, so it never stalls.
    assign stall_o = rst_n & (mem_stall_i | (hazard_s & ~flush_i));

    // ID/EX pipeline register: hold on downstream stall, else bubble or latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r     <= 1'b0;
            ex_pc_r        <= {XLEN{1'b0}};
            ex_rs1_r       <= {REG_AW{1'b0}};
            ex_rs2_r       <= {REG_AW{1'b0}};
            ex_rd_r        <= {REG_AW{1'b0}};
            ex_rs1_data_r  <= {XLEN{1'b0}};
            ex_rs2_data_r  <= {XLEN{1'b0}};
            ex_imm_r       <= {XLEN{1'b0}};
            ex_alu_op_r    <= 4'b0000;
            ex_asel_r      <= 2'b00;
            ex_bsel_r      <= 1'b0;
            ex_reg_write_r <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_mem_write_r <= 1'b0;
        end else if (mem_stall_i) begin
            ex_valid_r     <= ex_valid_r;
        end else if (bubble_s) begin
            ex_valid_r     <= 1'b0;
            ex_pc_r        <= {XLEN{1'b0}};
            ex_rs1_r       <= {REG_AW{1'b0}};
            ex_rs2_r       <= {REG_AW{1'b0}};
            ex_rd_r        <= {REG_AW{1'b0}};
            ex_rs1_data_r  <= {XLEN{1'b0}};
            ex_rs2_data_r  <= {XLEN{1'b0}};
            ex_imm_r       <= {XLEN{1'b0}};
            ex_alu_op_r    <= 4'b0000;
            ex_asel_r      <= 2'b00;
            ex_bsel_r      <= 1'b0;
            ex_reg_write_r <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_mem_write_r <= 1'b0;
        end else begin
            ex_valid_r     <= id_valid_i;
            ex_pc_r        <= id_pc_i;
            ex_rs1_r       <= id_rs1_i;
            ex_rs2_r       <= id_rs2_i;
            ex_rd_r        <= id_rd_i;
            ex_rs1_data_r  <= id_rs1_data_i;
            ex_rs2_data_r  <= id_rs2_data_i;
            ex_imm_r       <= id_imm_i;
            ex_alu_op_r    <= id_alu_op_i;
            ex_asel_r      <= id_asel_i;
            ex_bsel_r      <= id_bsel_i;
            ex_reg_write_r <= id_reg_write_i;
            ex_mem_read_r  <= id_mem_read_i;
            ex_mem_write_r <= id_mem_write_i;
        end
    end

`ifdef EX_FORWARD_EN
    // rs1 bypass: youngest producer (EX/MEM) wins, x0 never forwarded
    always_comb begin
        if (exmem_reg_write_i && (exmem_rd_i != {REG_AW{1'b0}}) && (exmem_rd_i == ex_rs1_r)) begin
            fwd_rs1_s = exmem_result_i;
        end else if (memwb_reg_write_i && (memwb_rd_i != {REG_AW{1'b0}}) && (memwb_rd_i == ex_rs1_r)) begin
            fwd_rs1_s = memwb_result_i;
        end else begin
            fwd_rs1_s = ex_rs1_data_r;
        end
    end

    // rs2 bypass: same priority as rs1
    always_comb begin
        if (exmem_reg_write_i && (exmem_rd_i != {REG_AW{1'b0}}) && (exmem_rd_i == ex_rs2_r)) begin
            fwd_rs2_s = exmem_result_i;
        end else if (memwb_reg_write_i && (memwb_rd_i != {REG_AW{1'b0}}) && (memwb_rd_i == ex_rs2_r)) begin
            fwd_rs2_s = memwb_result_i;
        end else begin
            fwd_rs2_s = ex_rs2_data_r;
        end
    end
`else
    // Without bypass the hazard logic guarantees the latched data is current
    always_comb begin
        fwd_rs1_s = ex_rs1_data_r;
        fwd_rs2_s = ex_rs2_data_r;
    end

    // Sources that only matter to the bypass network
    logic unused_fwd_s;
    assign unused_fwd_s = ^{ex_rs1_r, ex_rs2_r, exmem_result_i,
                            memwb_rd_i, memwb_reg_write_i, memwb_result_i};
`endif

    // ALU A operand source select; the reserved encoding reads as zero
    always_comb begin
        case (ex_asel_r)
            2'b00:   alu_a_o = fwd_rs1_s;
            2'b01:   alu_a_o = ex_pc_r;
            2'b10:   alu_a_o = {XLEN{1'b0}};
            default: alu_a_o = {XLEN{1'b0}};
        endcase
    end

    // ALU B operand source select
    always_comb begin
        if (ex_bsel_r) begin
            alu_b_o = ex_imm_r;
        end else begin
            alu_b_o = fwd_rs2_s;
        end
    end

    assign ex_store_data_o = fwd_rs2_s;
    assign ex_valid_o      = ex_valid_r;
    assign alu_op_o        = ex_alu_op_r;
    assign ex_rd_o         = ex_rd_r;
    assign ex_reg_write_o  = ex_reg_write_r;
    assign ex_mem_read_o   = ex_mem_read_r;
    assign ex_mem_write_o  = ex_mem_write_r;
    assign ex_pc_o         = ex_pc_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed self-checking bench for id_ex_operand_stage.
// Expectations follow the EX_FORWARD_EN build option when it is defined.

module tb_id_ex_operand_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              id_valid_i;
    logic [XLEN-1:0]   id_pc_i;
    logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic [XLEN-1:0]   id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [3:0]        id_alu_op_i;
    logic [1:0]        id_asel_i;
    logic              id_bsel_i;
    logic              id_reg_write_i, id_mem_read_i, id_mem_write_i;
    logic              id_uses_rs1_i, id_uses_rs2_i;
    logic              flush_i, mem_stall_i;
    logic [REG_AW-1:0] exmem_rd_i, memwb_rd_i;
    logic              exmem_reg_write_i, memwb_reg_write_i;
    logic [XLEN-1:0]   exmem_result_i, memwb_result_i;
    logic              stall_o, ex_valid_o;
    logic [XLEN-1:0]   alu_a_o, alu_b_o, ex_store_data_o, ex_pc_o;
    logic [3:0]        alu_op_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic              ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;

    int n_checks;
    int n_fail;

    id_ex_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_alu_op_i(id_alu_op_i),
        .id_asel_i(id_asel_i), .id_bsel_i(id_bsel_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .flush_i(flush_i), .mem_stall_i(mem_stall_i),
        .exmem_rd_i(exmem_rd_i), .exmem_reg_write_i(exmem_reg_write_i),
        .exmem_result_i(exmem_result_i),
        .memwb_rd_i(memwb_rd_i), .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_result_i(memwb_result_i),
        .stall_o(stall_o), .ex_valid_o(ex_valid_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
        .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_pc_o(ex_pc_o)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [3:0] op, input logic [1:0] asel, input logic bsel,
                          input logic rw, input logic mr, input logic mw,
                          input logic u1, input logic u2);
        id_valid_i = v;      id_pc_i = pc;
        id_rs1_i = rs1;      id_rs2_i = rs2;      id_rd_i = rd;
        id_rs1_data_i = d1;  id_rs2_data_i = d2;  id_imm_i = imm;
        id_alu_op_i = op;    id_asel_i = asel;    id_bsel_i = bsel;
        id_reg_write_i = rw; id_mem_read_i = mr;  id_mem_write_i = mw;
        id_uses_rs1_i = u1;  id_uses_rs2_i = u2;
    endtask

    task automatic id_clear();
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'b0000,
               2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic src_clear();
        exmem_rd_i = 5'd0; exmem_reg_write_i = 1'b0; exmem_result_i = 32'h0;
        memwb_rd_i = 5'd0; memwb_reg_write_i = 1'b0; memwb_result_i = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        flush_i = 1'b0;
        mem_stall_i = 1'b1;
        id_clear();
        src_clear();

        // Reset state, stall_o low even with mem_stall_i high
        #3;
        check_eq("rst_valid", 32'(ex_valid_o), 32'd0);
        check_eq("rst_op",    32'(alu_op_o),   32'd0);
        check_eq("rst_rd",    32'(ex_rd_o),    32'd0);
        check_eq("rst_rw",    32'(ex_reg_write_o), 32'd0);
        check_eq("rst_stall", 32'(stall_o),    32'd0);
        #9;
        mem_stall_i = 1'b0;
        rst_n = 1'b1;
        tick();

        // Forward priority on rs1
        set_id(1'b1, 32'h80, 5'd5, 5'd0, 5'd6, 32'h1, 32'h0, 32'h0, 4'b0000,
               2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        id_clear();
        exmem_rd_i = 5'd5; exmem_reg_write_i = 1'b1; exmem_result_i = 32'h10;
        memwb_rd_i = 5'd5; memwb_reg_write_i = 1'b1; memwb_result_i = 32'h20;
        settle();
        check_eq("fwd_valid", 32'(ex_valid_o), 32'd1);
        check_eq("fwd_pc",    ex_pc_o, 32'h80);
        check_eq("fwd_exmem", alu_a_o, FWD ? 32'h10 : 32'h1);
        exmem_reg_write_i = 1'b0;
        settle();
        check_eq("fwd_memwb", alu_a_o, FWD ? 32'h20 : 32'h1);
        exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd0; memwb_rd_i = 5'd0;
        settle();
        check_eq("fwd_x0", alu_a_o, 32'h1);
        src_clear();

        // Operand source selects
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'hAAA, 32'hBBB, 32'h24, 4'b0110,
               2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("sel_pc_a",  alu_a_o, 32'h100);
        check_eq("sel_imm_b", alu_b_o, 32'h24);
        check_eq("sel_op",    32'(alu_op_o), 32'h6);
        check_eq("sel_store", ex_store_data_o, 32'hBBB);
        set_id(1'b1, 32'h104, 5'd1, 5'd2, 5'd4, 32'hAAA, 32'hBBB, 32'h24, 4'b0000,
               2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("sel_a11",   alu_a_o, 32'h0);
        check_eq("sel_rs2_b", alu_b_o, 32'hBBB);

        // Load-use: lw x7 in EX, add reads x7
        set_id(1'b1, 32'h300, 5'd2, 5'd0, 5'd7, 32'h40, 32'h0, 32'h4, 4'b0000,
               2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 32'h304, 5'd3, 5'd7, 5'd8, 32'h5, 32'hBAD, 32'h0, 4'b0000,
               2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check_eq("lu_stall", 32'(stall_o), 32'd1);
        tick();
        exmem_rd_i = 5'd7; exmem_reg_write_i = 1'b1; exmem_result_i = 32'h44;
        settle();
        check_eq("lu_bubble", 32'(ex_valid_o), 32'd0);
        check_eq("lu_stall2", 32'(stall_o), FWD ? 32'd0 : 32'd1);
        tick();
        exmem_reg_write_i = 1'b0;
        memwb_rd_i = 5'd7; memwb_reg_write_i = 1'b1; memwb_result_i = 32'h77;
`ifdef EX_FORWARD_EN
        id_clear();
        settle();
        check_eq("lu_valid", 32'(ex_valid_o), 32'd1);
        check_eq("lu_rd",    32'(ex_rd_o), 32'd8);
        check_eq("lu_fwd_b", alu_b_o, 32'h77);
        check_eq("lu_a",     alu_a_o, 32'h5);
`else
        id_rs2_data_i = 32'h77;
        settle();
        check_eq("lu_bubble2", 32'(ex_valid_o), 32'd0);
        check_eq("lu_release", 32'(stall_o), 32'd0);
        tick();
        id_clear();
        memwb_reg_write_i = 1'b0;
        settle();
        check_eq("lu_valid", 32'(ex_valid_o), 32'd1);
        check_eq("lu_rd",    32'(ex_rd_o), 32'd8);
        check_eq("lu_b",     alu_b_o, 32'h77);
        check_eq("lu_a",     alu_a_o, 32'h5);
`endif
        src_clear();

        // Flush together with a load-use hazard
        set_id(1'b1, 32'h500, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 4'b0000,
               2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 32'h504, 5'd9, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 4'b0000,
               2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check_eq("fl_stall_pre", 32'(stall_o), 32'd1);
        flush_i = 1'b1;
        settle();
        check_eq("fl_stall", 32'(stall_o), 32'd0);
        tick();
        flush_i = 1'b0;
        id_clear();
        settle();
        check_eq("fl_valid", 32'(ex_valid_o), 32'd0);
        check_eq("fl_mr",    32'(ex_mem_read_o), 32'd0);
        check_eq("fl_rd",    32'(ex_rd_o), 32'd0);

        // A load to x0 never creates a hazard
        set_id(1'b1, 32'h600, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'b0000,
               2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 32'h604, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 4'b0000,
               2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check_eq("x0_stall", 32'(stall_o), 32'd0);

        // Downstream stall freezes a latched sub for three cycles
        set_id(1'b1, 32'h200, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h30, 4'b1000,
               2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 32'h204, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 4'b0111,
               2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("ms_stall", 32'(stall_o), 32'd1);
            check_eq("ms_op",    32'(alu_op_o), 32'h8);
            check_eq("ms_rd",    32'(ex_rd_o), 32'd10);
            check_eq("ms_pc",    ex_pc_o, 32'h200);
            check_eq("ms_b",     alu_b_o, 32'h30);
            tick();
        end
        check_eq("ms_hold_op", 32'(alu_op_o), 32'h8);
        check_eq("ms_hold_a",  alu_a_o, 32'h200);
        mem_stall_i = 1'b0;
        settle();
        check_eq("ms_rel_stall", 32'(stall_o), 32'd0);
        tick();
        check_eq("ms_next_op", 32'(alu_op_o), 32'h7);
        check_eq("ms_next_rd", 32'(ex_rd_o), 32'd11);
        check_eq("ms_next_pc", ex_pc_o, 32'h204);

        // Store with rs2 produced in EX/MEM
        exmem_rd_i = 5'd12; exmem_reg_write_i = 1'b1; exmem_result_i = 32'hDEADBEEF;
        set_id(1'b1, 32'h400, 5'd13, 5'd12, 5'd0, 32'h1000, 32'h1, 32'h8, 4'b0000,
               2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        check_eq("st_stall", 32'(stall_o), FWD ? 32'd0 : 32'd1);
        tick();
`ifdef EX_FORWARD_EN
        id_clear();
        settle();
`else
        check_eq("st_bubble", 32'(ex_valid_o), 32'd0);
        exmem_reg_write_i = 1'b0;
        memwb_rd_i = 5'd12; memwb_reg_write_i = 1'b1; memwb_result_i = 32'hDEADBEEF;
        id_rs2_data_i = 32'hDEADBEEF;
        settle();
        check_eq("st_release", 32'(stall_o), 32'd0);
        tick();
        id_clear();
        settle();
`endif
        check_eq("st_b",     alu_b_o, 32'h8);
        check_eq("st_data",  ex_store_data_o, 32'hDEADBEEF);
        check_eq("st_a",     alu_a_o, 32'h1000);
        check_eq("st_mw",    32'(ex_mem_write_o), 32'd1);
        src_clear();

        // Asynchronous reset between edges with a valid xor latched
        set_id(1'b1, 32'h700, 5'd0, 5'd0, 5'd14, 32'h0, 32'h0, 32'h0, 4'b0100,
               2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        id_clear();
        check_eq("mr_pre_valid", 32'(ex_valid_o), 32'd1);
        check_eq("mr_pre_op",    32'(alu_op_o), 32'h4);
        mem_stall_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mr_valid", 32'(ex_valid_o), 32'd0);
        check_eq("mr_op",    32'(alu_op_o), 32'd0);
        check_eq("mr_rd",    32'(ex_rd_o), 32'd0);
        check_eq("mr_rw",    32'(ex_reg_write_o), 32'd0);
        check_eq("mr_stall", 32'(stall_o), 32'd0);
        #1;
        rst_n = 1'b1;
        mem_stall_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-side operand selection, directly upstream of the ALU.
- Latches decoded instructions, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's A, B and ALUOp inputs.
- Detects load-use hazards, stalls decode, and inserts bubbles.
- Handles pipeline flush from branch/jump resolution.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  decode holds a valid instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register indices
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register file read data (regfile is write-before-read)
- id_imm_i  in  XLEN  sign-extended immediate
- id_alu_op_i  in  4  ALU opcode: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and
- id_asel_i  in  2  A source: 00 rs1, 01 PC, 10 zero
- id_bsel_i  in  1  B source: 0 rs2, 1 imm
- id_reg_write_i, id_mem_read_i, id_mem_write_i  in  1  control bits
- id_uses_rs1_i, id_uses_rs2_i  in  1  instruction actually reads rs1/rs2
- flush_i  in  1  kill the instruction entering EX
- mem_stall_i  in  1  downstream busy: freeze stage
- exmem_rd_i  in  REG_AW, exmem_reg_write_i  in  1, exmem_result_i  in  XLEN  EX/MEM forwarding source
- memwb_rd_i  in  REG_AW, memwb_reg_write_i  in  1, memwb_result_i  in  XLEN  MEM/WB forwarding source
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid_o  out  1  EX holds a real instruction
- alu_a_o, alu_b_o  out  XLEN  ALU operands (combinational from register and forward muxes)
- alu_op_o  out  4  registered ALUOp
- ex_store_data_o  out  XLEN  forwarded rs2 for stores
- ex_rd_o  out  REG_AW, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o  out  1  to EX/MEM
- ex_pc_o  out  XLEN  registered PC

Behaviour:
- Reset (rst_n low, asynchronous): every registered field is 0, so ex_valid_o=0, alu_op_o=0000, ex_rd_o=0 and all control bits are 0. stall_o=0 while in reset.
- Latency: one cycle from decode inputs to registered EX outputs. alu_a_o/alu_b_o are combinational off the register and forward muxes in the same cycle.
- Update priority at each rising edge:
  1. mem_stall_i: hold all registers.
  2. flush_i: load a bubble (valid and all control bits 0, alu_op 0000).
  3. Load-use hazard: load a bubble.
  4. Otherwise: latch the decode inputs, with ex_valid = id_valid_i.
- Load-use hazard = ex_valid & ex_mem_read & ex_rd≠0 & id_valid_i & ((id_uses_rs1_i & id_rs1_i==ex_rd) | (id_uses_rs2_i & id_rs2_i==ex_rd)).
- stall_o = mem_stall_i | (hazard & ~flush_i).
- Forwarding per source operand (rs1, rs2) uses the registered index and data:
  - Select exmem_result_i if exmem_reg_write_i & exmem_rd_i≠0 & exmem_rd_i==idx.
  - Else memwb_result_i if memwb_reg_write_i & memwb_rd_i≠0 & memwb_rd_i==idx.
  - Else the registered data.
  - EX/MEM takes priority. x0 is never forwarded and never a hazard.
- alu_a_o: fwd rs1 / ex_pc / 0 per asel. asel=11 gives 0.
- alu_b_o: fwd rs2 or imm per bsel.
- ex_store_data_o is always fwd rs2, independent of bsel.
- While ex_valid_o=0, outputs still follow the register contents. Downstream must qualify all outputs with ex_valid_o.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - Forward muxes are removed; operands always come from the registered data.
  - The hazard rule widens: stall on any valid-id read of a nonzero register matching ex_rd (ex_valid & ex_reg_write) or exmem_rd_i (exmem_reg_write_i).
  - MEM/WB needs no check because the regfile is write-before-read.
  - Bubble and priority rules are unchanged.

Test Plan:
- Reset mid-stream: assert rst_n=0 asynchronously between edges with a valid instruction latched → ex_valid_o, control outputs and alu_op_o are 0 immediately; stall_o=0.
- Forward priority: EX instr rs1=5, rs1_data=1; exmem rd=5 result=0x10; memwb rd=5 result=0x20 → alu_a_o=0x10. Drop exmem_reg_write → 0x20. Set rd=0 on both → 1.
- Load-use: EX lw x7, then decode add rs2=7 → stall_o=1 for one cycle, next cycle ex_valid_o=0 (bubble), then add latched with forwarding of x7 from MEM/WB.
- Flush plus hazard in the same cycle → stall_o=0, bubble latched, ex_valid_o=0 next cycle.
- mem_stall_i=1 for 3 cycles with sub latched → alu_op_o=1000 and all registered outputs are held, stall_o=1. Release → next instruction latches.
- Store forwarding: sw with bsel=1, imm=8, rs2 forwarded from EX/MEM 0xDEADBEEF → alu_b_o=8, ex_store_data_o=0xDEADBEEF. With EX_FORWARD_EN undefined → stall_o=1 until the producer leaves EX/MEM.
